// File: rtl/integral_image_core.sv
// Streaming integral image over a square ROW_SIZE x ROW_SIZE raster frame, one pixel per clock.
// Latency: S is registered one cycle after the pixel is accepted. There is no backpressure, so every non-reset edge consumes a sample.
module integral_image_core #(
  parameter int W        = 8,
  parameter int ROW_SIZE = 4,
  parameter int W_SUM    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     new_sample,
  output logic [W_SUM-1:0] S
);

  localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROW_SIZE - 1);

  logic [CW-1:0]    col;
  logic [CW-1:0]    row;
  logic [W_SUM-1:0] row_sum;
  logic [W_SUM-1:0] row_buf [ROW_SIZE];

  logic [W_SUM-1:0] pix;
  logic [W_SUM-1:0] row_sum_next;
  logic [W_SUM-1:0] above;
  logic [W_SUM-1:0] integ;

  always_comb begin
    pix          = W_SUM'(new_sample);
    row_sum_next = (col == '0) ? pix : row_sum + pix;
    // Row 0 must not see the previous frame's buffer contents.
    above        = (row == '0) ? '0 : row_buf[col];
    integ        = row_sum_next + above;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      S       <= '0;
      col     <= '0;
      row     <= '0;
      row_sum <= '0;
      for (int i = 0; i < ROW_SIZE; i++) row_buf[i] <= '0;
    end else begin
      S            <= integ;
      row_sum      <= row_sum_next;
      row_buf[col] <= integ;
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_integral_image_core.sv
// Directed bench for integral_image_core: frame-sum model plus hand-computed literal expectations.
module tb_integral_image_core;

  localparam int W  = 8;
  localparam int RS = 4;
  localparam int WS = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  new_sample = '0;
  logic [WS-1:0] S;

  always #5 clock = ~clock;

  integral_image_core #(.W(W), .ROW_SIZE(RS), .W_SUM(WS)) dut (
    .clock      (clock),
    .reset      (reset),
    .new_sample (new_sample),
    .S          (S)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic          chk_en   = 1'b0;
  logic [WS-1:0] exp_s    = '0;
  logic          lit_en   = 1'b0;
  logic [WS-1:0] lit_val  = '0;
  logic          mark_en  = 1'b0;
  logic          win_en   = 1'b0;
  logic [WS-1:0] mark     = '0;

  logic [W-1:0]  pix19 [16] = '{1,2,3,4, 5,6,7,8, 1,2,3,4, 5,6,7,8};
  logic [WS-1:0] ref19 [16] = '{1,3,6,10, 6,14,24,36, 7,17,30,46, 12,28,48,72};

  // Model: remembers the current frame's pixels and sums the whole rectangle each cycle.
  int fr [RS][RS];
  int my_y = 0;
  int my_x = 0;

  task automatic model(input logic r, input logic [W-1:0] v);
    int sum;
    if (r) begin
      exp_s = '0;
      my_y  = 0;
      my_x  = 0;
    end else begin
      fr[my_y][my_x] = int'(v);
      sum = 0;
      for (int y = 0; y <= my_y; y++)
        for (int x = 0; x <= my_x; x++)
          sum += fr[y][x];
      exp_s = sum[WS-1:0];
      my_x++;
      if (my_x == RS) begin
        my_x = 0;
        my_y = (my_y == RS - 1) ? 0 : my_y + 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] v,
                      input logic le, input logic [WS-1:0] lv,
                      input logic mk, input logic wn);
    reset      = r;
    new_sample = v;
    @(posedge clock);
    model(r, v);
    lit_en  = le;
    lit_val = lv;
    mark_en = mk;
    win_en  = wn;
    #1;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      n_checks++;
      if (S !== exp_s) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t S=%0d expected %0d", $time, S, exp_s);
      end
      if (lit_en) begin
        n_checks++;
        if (S !== lit_val) begin
          n_fail++;
          $display("FAIL literal t=%0t S=%0d expected %0d", $time, S, lit_val);
        end
      end
      if (mark_en) mark = S;
      if (win_en) begin
        n_checks++;
        if (WS'(S - mark) !== 16'd39) begin
          n_fail++;
          $display("FAIL window t=%0t I(2,3)-I(2,0)=%0d expected 39", $time, WS'(S - mark));
        end
      end
    end
  end

  initial begin
    chk_en = 1'b1;
    step(1'b1, 8'hAA, 1'b1, '0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, '0, 1'b0, 1'b0);

    // Reference frame, then the same frame back-to-back.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++)
        step(1'b0, pix19[i], 1'b1, ref19[i], (i == 8), (i == 11));

    // All ones: S(y,x) = (y+1)*(x+1).
    for (int i = 0; i < 16; i++)
      step(1'b0, 8'd1, (i == 6) || (i == 15), (i == 6) ? 16'd6 : 16'd16, 1'b0, 1'b0);

    // All 255: final value 16*255.
    for (int i = 0; i < 16; i++)
      step(1'b0, 8'd255, (i == 15), 16'd4080, 1'b0, 1'b0);

    // Random frame, model-checked only.
    for (int i = 0; i < 16; i++)
      step(1'b0, 8'($urandom_range(0, 255)), 1'b0, '0, 1'b0, 1'b0);

    // Mid-frame reset after six samples, then a full fresh frame.
    for (int i = 0; i < 6; i++)
      step(1'b0, pix19[i], 1'b1, ref19[i], 1'b0, 1'b0);
    step(1'b1, 8'd99, 1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      step(1'b0, pix19[i], 1'b1, ref19[i], (i == 8), (i == 11));

    step(1'b0, 8'd0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
